mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory port between the instruction cache (master 0) and the data cache (master 1).
- Admits one transaction at a time and steers the reply back to the master that issued it.
- Fairness is 2-way round-robin.
- Sits between the two cache wrappers and the memory/bus bridge.

Parameters:
ADDR_WIDTH, 64, request address width
DATA_WIDTH, 64, data width of a request or reply beat
MASK_WIDTH, DATA_WIDTH/8, byte write-mask width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- m_req_valid  in  2  per-master request valid; bit0 = icache, bit1 = dcache
- m_req_ready  out  2  per-master request accepted
- m_req_wen  in  2  per-master write enable (icache ties 0)
- m_req_addr  in  2*ADDR_WIDTH  per-master address; master i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_req_wdata  in  2*DATA_WIDTH  per-master write data, sliced the same way
- m_req_wmask  in  2*MASK_WIDTH  per-master byte mask, sliced the same way
- m_resp_valid  out  2  per-master reply valid
- m_resp_ready  in  2  per-master reply ready
- m_resp_rdata  out  DATA_WIDTH  reply data, shared by both masters
- mem_req_valid  out  1  request valid to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_wen  out  1  write enable to memory
- mem_req_addr  out  ADDR_WIDTH  address to memory
- mem_req_wdata  out  DATA_WIDTH  write data to memory
- mem_req_wmask  out  MASK_WIDTH  byte mask to memory
- mem_resp_valid  in  1  memory reply valid (reads and writes each return exactly one)
- mem_resp_ready  out  1  arbiter accepts reply
- mem_resp_rdata  in  DATA_WIDTH  memory reply data
- owner  out  1  index of the currently granted master; debug/perf only

Behaviour:
- FSM states: IDLE, REQ, RESP. Registers: state, owner, last (last master served).
- Reset values (asynchronous):
  - state = IDLE, owner = 0, last = 0.
  - All valid/ready outputs 0.
  - Data outputs are 0 while not granted.
- IDLE:
  - Samples m_req_valid. If both are 0, stay in IDLE.
  - If exactly one bit is set, owner <= that master.
  - If both are set, owner <= ~last; after reset the dcache wins the first tie.
  - Moves to REQ on the next edge; the grant is registered, so no combinational path from m_req_valid to mem_req_valid.
- REQ:
  - mem_req_valid = m_req_valid[owner]; mem_req_* muxed from owner's slices.
  - m_req_ready[owner] = mem_req_ready; the other ready bit is 0.
  - On handshake (valid & ready): go to RESP.
  - If m_req_valid[owner] drops before the handshake (abort): return to IDLE; last is not updated.
- RESP:
  - m_resp_valid[owner] = mem_resp_valid; mem_resp_ready = m_resp_ready[owner]; m_resp_rdata = mem_resp_rdata.
  - The other master's m_resp_valid is 0.
  - On handshake: last <= owner, state <= IDLE.
- Minimum latency from request valid to request handshake is 1 cycle; idle turnaround after a reply is 1 cycle.
- Exactly one outstanding transaction; new requests are never accepted in REQ or RESP. Non-owner requests wait, with valid held per protocol.
- A master must hold its address, data, mask and wen stable while valid and not ready. The arbiter does not latch request fields.
- mem_resp_valid outside RESP is a protocol error: it is ignored and mem_resp_ready = 0.
- Reset asserted mid-transaction forces IDLE immediately. The memory side is assumed to be reset concurrently.

Test Plan:
1. Icache-only read of addr 0x8000_0000, mem ready after 2 cycles, reply 0x1111 → mem_req_addr = 0x8000_0000, wen 0; m_resp_valid = 2'b01, rdata = 0x1111; state back to IDLE.
2. Both masters request in the same cycle right after reset → dcache is served first (owner = 1), icache second; owner sequence 1, 0; no overlap of mem_req_valid.
3. Both masters hold requests continuously for 6 transactions → grants alternate 1, 0, 1, 0, 1, 0; neither master waits more than one transaction.
4. Dcache write addr 0x100, wdata 0xDEAD_BEEF, wmask 0x0F → memory sees identical fields with wen = 1; one reply acknowledged to dcache only.
5. Icache drops valid while in REQ before mem_req_ready → returns to IDLE, last unchanged, no memory handshake; a following dcache request is granted normally.
6. Assert rst during RESP with mem_resp_valid high → all outputs 0 the same cycle; state IDLE; the next tie goes to the dcache.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-master round-robin arbiter for the shared memory port.
// One transaction in flight; the reply is steered back to the issuing master.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              m_req_valid,
  output logic [1:0]              m_req_ready,
  input  logic [1:0]              m_req_wen,
  input  logic [2*ADDR_WIDTH-1:0] m_req_addr,
  input  logic [2*DATA_WIDTH-1:0] m_req_wdata,
  input  logic [2*MASK_WIDTH-1:0] m_req_wmask,
  output logic [1:0]              m_resp_valid,
  input  logic [1:0]              m_resp_ready,
  output logic [DATA_WIDTH-1:0]   m_resp_rdata,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_wen,
  output logic [ADDR_WIDTH-1:0]   mem_req_addr,
  output logic [DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [MASK_WIDTH-1:0]   mem_req_wmask,
  input  logic                    mem_resp_valid,
  output logic                    mem_resp_ready,
  input  logic [DATA_WIDTH-1:0]   mem_resp_rdata,
  output logic                    owner
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t state;
  logic   last;

  logic                  sel_valid;
  logic                  sel_wen;
  logic                  sel_resp_ready;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [MASK_WIDTH-1:0] sel_wmask;
  logic                  in_req;
  logic                  in_resp;

  assign sel_valid      = m_req_valid[owner];
  assign sel_wen        = m_req_wen[owner];
  assign sel_resp_ready = m_resp_ready[owner];
  assign sel_addr  = owner ? m_req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                           : m_req_addr[ADDR_WIDTH-1:0];
  assign sel_wdata = owner ? m_req_wdata[2*DATA_WIDTH-1:DATA_WIDTH]
                           : m_req_wdata[DATA_WIDTH-1:0];
  assign sel_wmask = owner ? m_req_wmask[2*MASK_WIDTH-1:MASK_WIDTH]
                           : m_req_wmask[MASK_WIDTH-1:0];

  assign in_req  = (state == REQ);
  assign in_resp = (state == RESP);

  // Grant is decided in IDLE and registered; REQ/RESP only follow owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|m_req_valid) begin
            owner <= (&m_req_valid) ? ~last : m_req_valid[1];
            state <= REQ;
          end
        end
        REQ: begin
          if (!sel_valid) begin
            state <= IDLE;
          end else if (mem_req_ready) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (mem_resp_valid && sel_resp_ready) begin
            last  <= owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    m_req_ready    = 2'b00;
    m_resp_valid   = 2'b00;
    m_resp_rdata   = '0;
    mem_req_valid  = 1'b0;
    mem_req_wen    = 1'b0;
    mem_req_addr   = '0;
    mem_req_wdata  = '0;
    mem_req_wmask  = '0;
    mem_resp_ready = 1'b0;
    if (in_req) begin
      mem_req_valid      = sel_valid;
      mem_req_wen        = sel_wen;
      mem_req_addr       = sel_addr;
      mem_req_wdata      = sel_wdata;
      mem_req_wmask      = sel_wmask;
      m_req_ready[owner] = mem_req_ready;
    end
    if (in_resp) begin
      m_resp_valid[owner] = mem_resp_valid;
      m_resp_rdata        = mem_resp_rdata;
      mem_resp_ready      = sel_resp_ready;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter.
// Masters and memory are modelled in one cycle loop driven at negedge.
module tb_mem_port_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int MW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      m_req_valid;
  logic [1:0]      m_req_ready;
  logic [1:0]      m_req_wen;
  logic [2*AW-1:0] m_req_addr;
  logic [2*DW-1:0] m_req_wdata;
  logic [2*MW-1:0] m_req_wmask;
  logic [1:0]      m_resp_valid;
  logic [1:0]      m_resp_ready;
  logic [DW-1:0]   m_resp_rdata;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_req_wen;
  logic [AW-1:0]   mem_req_addr;
  logic [DW-1:0]   mem_req_wdata;
  logic [MW-1:0]   mem_req_wmask;
  logic            mem_resp_valid;
  logic            mem_resp_ready;
  logic [DW-1:0]   mem_resp_rdata;
  logic            owner;

  mem_port_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .m_req_valid    (m_req_valid),
    .m_req_ready    (m_req_ready),
    .m_req_wen      (m_req_wen),
    .m_req_addr     (m_req_addr),
    .m_req_wdata    (m_req_wdata),
    .m_req_wmask    (m_req_wmask),
    .m_resp_valid   (m_resp_valid),
    .m_resp_ready   (m_resp_ready),
    .m_resp_rdata   (m_resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_wen    (mem_req_wen),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .mem_resp_rdata (mem_resp_rdata),
    .owner          (owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } req_t;

  typedef struct {
    logic m;
    req_t r;
  } exp_req_t;

  typedef struct {
    logic          m;
    logic [DW-1:0] d;
  } exp_resp_t;

  req_t      mq0[$];
  req_t      mq1[$];
  exp_req_t  exp_req[$];
  exp_resp_t exp_resp[$];

  int            checks = 0;
  int            errors = 0;
  int            rdelay = 0;
  int            rcnt = 0;
  int            rwait = 0;
  int            stall = 0;
  logic          resp_pending = 1'b0;
  logic [DW-1:0] resp_data = '0;
  logic [DW-1:0] key = 64'h0123_4567_89AB_CDEF;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(logic m, logic wen, logic [AW-1:0] addr,
                      logic [DW-1:0] wdata, logic [MW-1:0] wmask,
                      logic [DW-1:0] rdata);
    req_t r;
    r.wen = wen;
    r.addr = addr;
    r.wdata = wdata;
    r.wmask = wmask;
    if (m) mq1.push_back(r);
    else mq0.push_back(r);
    exp_req.push_back('{m, r});
    exp_resp.push_back('{m, rdata});
  endtask

  task automatic sample();
    exp_req_t  e;
    exp_resp_t q;
    if (mem_req_valid && mem_req_ready) begin
      check("req_unexpected", exp_req.size(), exp_req.size() == 0 ? 1 : exp_req.size());
      if (exp_req.size() != 0) begin
        e = exp_req.pop_front();
        check("owner", owner, e.m);
        check("m_req_ready", m_req_ready, e.m ? 2'b10 : 2'b01);
        check("mem_req_wen", mem_req_wen, e.r.wen);
        check("mem_req_addr", mem_req_addr, e.r.addr);
        check("mem_req_wdata", mem_req_wdata, e.r.wdata);
        check("mem_req_wmask", mem_req_wmask, e.r.wmask);
        if (e.m && mq1.size() != 0) void'(mq1.pop_front());
        if (!e.m && mq0.size() != 0) void'(mq0.pop_front());
      end
      resp_pending = 1'b1;
      rwait = 1;
      resp_data = mem_req_addr ^ key;
      rcnt = 0;
    end else if (mem_req_valid) begin
      rcnt++;
    end else begin
      rcnt = 0;
    end
    if (mem_resp_valid && mem_resp_ready) begin
      check("resp_unexpected", exp_resp.size() != 0, 1);
      if (exp_resp.size() != 0) begin
        q = exp_resp.pop_front();
        check("m_resp_valid", m_resp_valid, q.m ? 2'b10 : 2'b01);
        check("m_resp_rdata", m_resp_rdata, q.d);
      end
      resp_pending = 1'b0;
    end else if (resp_pending && rwait > 0) begin
      rwait--;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    m_req_valid = {mq1.size() != 0, mq0.size() != 0};
    m_req_wen = 2'b00;
    m_req_addr = '0;
    m_req_wdata = '0;
    m_req_wmask = '0;
    if (mq0.size() != 0) begin
      m_req_wen[0] = mq0[0].wen;
      m_req_addr[AW-1:0] = mq0[0].addr;
      m_req_wdata[DW-1:0] = mq0[0].wdata;
      m_req_wmask[MW-1:0] = mq0[0].wmask;
    end
    if (mq1.size() != 0) begin
      m_req_wen[1] = mq1[0].wen;
      m_req_addr[2*AW-1:AW] = mq1[0].addr;
      m_req_wdata[2*DW-1:DW] = mq1[0].wdata;
      m_req_wmask[2*MW-1:MW] = mq1[0].wmask;
    end
    mem_req_ready = (rcnt >= rdelay);
    mem_resp_valid = resp_pending && (rwait == 0);
    mem_resp_rdata = resp_pending ? resp_data : '0;
    m_resp_ready = (stall > 0) ? 2'b00 : 2'b11;
    if (stall > 0) stall--;
    #1;
    sample();
  endtask

  task automatic clear_model();
    mq0.delete();
    mq1.delete();
    exp_req.delete();
    exp_resp.delete();
    resp_pending = 1'b0;
    rcnt = 0;
    rwait = 0;
  endtask

  task automatic idle_check(string tag);
    cycle();
    check({tag, "_mem_req_valid"}, mem_req_valid, 0);
    check({tag, "_m_req_ready"}, m_req_ready, 0);
    check({tag, "_m_resp_valid"}, m_resp_valid, 0);
    check({tag, "_mem_resp_ready"}, mem_resp_ready, 0);
    check({tag, "_mem_req_addr"}, mem_req_addr, 0);
  endtask

  task automatic drain(string tag, int budget);
    int n = 0;
    while ((mq0.size() != 0 || mq1.size() != 0 || exp_req.size() != 0 ||
            exp_resp.size() != 0 || resp_pending) && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_left"}, mq0.size() + mq1.size() + exp_req.size() +
          exp_resp.size() + int'(resp_pending), 0);
    clear_model();
    idle_check(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_model();
    mem_resp_valid = 1'b0;
    mem_req_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    m_req_valid = '0;
    m_req_wen = '0;
    m_req_addr = '0;
    m_req_wdata = '0;
    m_req_wmask = '0;
    m_resp_ready = 2'b11;
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 64'hFFFF;
    #12;
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_m_req_ready", m_req_ready, 0);
    check("rst_m_resp_valid", m_resp_valid, 0);
    check("rst_mem_resp_ready", mem_resp_ready, 0);
    check("rst_m_resp_rdata", m_resp_rdata, 0);
    check("rst_owner", owner, 0);
    do_reset();

    // 1: icache read, memory ready after 2 cycles
    rdelay = 2;
    key = 64'h8000_1111;
    push(1'b0, 1'b0, 64'h8000_0000, 64'h0, 8'h00, 64'h1111);
    drain("t1", 40);
    rdelay = 0;
    key = 64'h0123_4567_89AB_CDEF;

    // 2: tie right after reset goes to dcache first
    do_reset();
    push(1'b1, 1'b0, 64'h2000, 64'h0, 8'h00, 64'h2000 ^ key);
    push(1'b0, 1'b0, 64'h3000, 64'h0, 8'h00, 64'h3000 ^ key);
    drain("t2", 40);

    // 3: continuous contention alternates grants
    for (int i = 0; i < 3; i++) begin
      push(1'b1, 1'b0, 64'h4000 + 64'(i * 8), 64'h0, 8'h00,
           (64'h4000 + 64'(i * 8)) ^ key);
      push(1'b0, 1'b0, 64'h5000 + 64'(i * 8), 64'h0, 8'h00,
           (64'h5000 + 64'(i * 8)) ^ key);
    end
    drain("t3", 120);

    // 4: dcache write, reply held off by a stalled master
    stall = 6;
    push(1'b1, 1'b1, 64'h100, 64'hDEAD_BEEF, 8'h0F, 64'h100 ^ key);
    drain("t4", 40);

    // 5: icache aborts in REQ; last must still point at dcache
    rdelay = 1000;
    mq0.push_back('{1'b0, 64'h6000, 64'h0, 8'h00});
    cycle();
    cycle();
    check("t5_pending", mem_req_valid, 1);
    mq0.delete();
    cycle();
    check("t5_dropped", mem_req_valid, 0);
    cycle();
    check("t5_idle", mem_req_valid, 0);
    rdelay = 0;
    push(1'b0, 1'b0, 64'h7000, 64'h0, 8'h00, 64'h7000 ^ key);
    push(1'b1, 1'b0, 64'h7100, 64'h0, 8'h00, 64'h7100 ^ key);
    drain("t5_tie", 60);
    push(1'b1, 1'b0, 64'h7200, 64'h0, 8'h00, 64'h7200 ^ key);
    drain("t5_d", 40);

    // 6: reset while a reply is being offered
    push(1'b0, 1'b0, 64'h40, 64'h0, 8'h00, 64'h40 ^ key);
    n = 0;
    while (m_resp_valid == 2'b00 && n < 20) begin
      cycle();
      n++;
    end
    check("t6_resp_seen", m_resp_valid, 2'b01);
    #1 rst = 1'b1;
    #1;
    check("t6_mem_req_valid", mem_req_valid, 0);
    check("t6_m_req_ready", m_req_ready, 0);
    check("t6_m_resp_valid", m_resp_valid, 0);
    check("t6_mem_resp_ready", mem_resp_ready, 0);
    check("t6_m_resp_rdata", m_resp_rdata, 0);
    check("t6_owner", owner, 0);
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    push(1'b1, 1'b0, 64'h8100, 64'h0, 8'h00, 64'h8100 ^ key);
    push(1'b0, 1'b0, 64'h8200, 64'h0, 8'h00, 64'h8200 ^ key);
    drain("t6_tie", 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
